// File: rtl/lfsr_period_monitor.sv
// lfsr_period_monitor
// Watches the word stream of a small LFSR. On request it captures a reference
// word, then counts valid samples until that word recurs, reporting the
// sequence period. An all-zero word (LFSR lockup) or a sequence that never
// recurs within MAX_PERIOD samples terminates the measurement with a fault flag.

module lfsr_period_monitor #(
    parameter int WIDTH      = 4,
    parameter int CNT_W      = 8,
    parameter int MAX_PERIOD = 255
) (
    input  logic             clk,
    input  logic             res,
    input  logic             en,
    input  logic [WIDTH-1:0] w_in,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] period,
    output logic             err_lock,
    output logic             err_tout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   ref_word;
    logic [WIDTH-1:0]   ref_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [CNT_W-1:0]   cnt_inc;
    logic [CNT_W-1:0]   period_nxt;
    logic               lock_nxt;
    logic               tout_nxt;

    // State and datapath registers; an active-low reset discards any measurement in progress.
    always_ff @(posedge clk) begin
        if (!res) begin
            state    <= IDLE;
            ref_word <= '0;
            cnt      <= '0;
            period   <= '0;
            err_lock <= 1'b0;
            err_tout <= 1'b0;
        end else begin
            state    <= state_nxt;
            ref_word <= ref_nxt;
            cnt      <= cnt_nxt;
            period   <= period_nxt;
            err_lock <= lock_nxt;
            err_tout <= tout_nxt;
        end
    end

    // Next-state logic: arm from any resting state, then look for recurrence, lockup or timeout.
    always_comb begin
        state_nxt  = state;
        ref_nxt    = ref_word;
        cnt_nxt    = cnt;
        period_nxt = period;
        lock_nxt   = err_lock;
        tout_nxt   = err_tout;
        cnt_inc    = cnt + CNT_W'(1);

        case (state)
            COUNT: begin
                if (en) begin
                    if (w_in == ref_word) begin
                        period_nxt = cnt_inc;
                        state_nxt  = DONE;
                    end else if (w_in == '0) begin
                        lock_nxt  = 1'b1;
                        state_nxt = FAULT;
                    end else if (cnt_inc == CNT_W'(MAX_PERIOD)) begin
                        tout_nxt  = 1'b1;
                        state_nxt = FAULT;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
            end
            default: begin
                if (start && en) begin
                    ref_nxt  = w_in;
                    cnt_nxt  = '0;
                    lock_nxt = 1'b0;
                    tout_nxt = 1'b0;
                    if (w_in == '0) begin
                        lock_nxt  = 1'b1;
                        state_nxt = FAULT;
                    end else begin
                        state_nxt = COUNT;
                    end
                end
            end
        endcase
    end

    // Status outputs decode directly from the registered state.
    always_comb begin
        busy = (state == COUNT);
        done = (state == DONE);
    end

endmodule

// File: tb/tb_lfsr_period_monitor.sv
// tb_lfsr_period_monitor
// Drives two monitors (default MAX_PERIOD and MAX_PERIOD=10) from the same
// stimulus: directed LFSR scenarios followed by a randomized stream. Every
// output is compared each cycle against a sample-level reference model.

module tb_lfsr_period_monitor;

    logic       clk = 1'b0;
    logic       res;
    logic       en;
    logic       start;
    logic [3:0] w_in;

    logic       busy_a, done_a, err_lock_a, err_tout_a;
    logic [7:0] period_a;
    logic       busy_b, done_b, err_lock_b, err_tout_b;
    logic [7:0] period_b;

    int nVectors     = 0;
    int nMiscompares = 0;

    int mPhase   [2];
    int mRef     [2];
    int mSamples [2];
    int mPeriod  [2];
    int mMax     [2] = '{255, 10};

    // Free-running clock
    always #5 clk = ~clk;

    lfsr_period_monitor #(.WIDTH(4), .CNT_W(8), .MAX_PERIOD(255)) dut_a (
        .clk(clk), .res(res), .en(en), .w_in(w_in), .start(start),
        .busy(busy_a), .done(done_a), .period(period_a),
        .err_lock(err_lock_a), .err_tout(err_tout_a)
    );

    lfsr_period_monitor #(.WIDTH(4), .CNT_W(8), .MAX_PERIOD(10)) dut_b (
        .clk(clk), .res(res), .en(en), .w_in(w_in), .start(start),
        .busy(busy_b), .done(done_b), .period(period_b),
        .err_lock(err_lock_b), .err_tout(err_tout_b)
    );

    // Fibonacci LFSR for x^4 + x^3 + 1 (maximal length, period 15)
    function automatic logic [3:0] lfsrNext(input logic [3:0] w);
        return {w[2:0], w[3] ^ w[2]};
    endfunction

    // Reference model; phase 0 idle, 1 measuring, 2 result, 3 lockup, 4 timeout
    function automatic void modelStep(input logic r, input logic e, input logic s,
                                      input logic [3:0] w);
        for (int i = 0; i < 2; i++) begin
            if (!r) begin
                mPhase[i]   = 0;
                mRef[i]     = 0;
                mSamples[i] = 0;
                mPeriod[i]  = 0;
            end else if (e) begin
                if (mPhase[i] != 1) begin
                    if (s) begin
                        mRef[i]     = int'(w);
                        mSamples[i] = 0;
                        mPhase[i]   = (w == 4'd0) ? 3 : 1;
                    end
                end else begin
                    mSamples[i] = mSamples[i] + 1;
                    if (int'(w) == mRef[i]) begin
                        mPeriod[i] = mSamples[i];
                        mPhase[i]  = 2;
                    end else if (w == 4'd0) begin
                        mPhase[i] = 3;
                    end else if (mSamples[i] == mMax[i]) begin
                        mPhase[i] = 4;
                    end
                end
            end
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nVectors++;
        if (observed !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic compareAll(input string tag);
        checkOutput({tag, "/a.busy"},   32'(busy_a),     32'(mPhase[0] == 1));
        checkOutput({tag, "/a.done"},   32'(done_a),     32'(mPhase[0] == 2));
        checkOutput({tag, "/a.lock"},   32'(err_lock_a), 32'(mPhase[0] == 3));
        checkOutput({tag, "/a.tout"},   32'(err_tout_a), 32'(mPhase[0] == 4));
        checkOutput({tag, "/a.period"}, 32'(period_a),   32'(mPeriod[0]));
        checkOutput({tag, "/b.busy"},   32'(busy_b),     32'(mPhase[1] == 1));
        checkOutput({tag, "/b.done"},   32'(done_b),     32'(mPhase[1] == 2));
        checkOutput({tag, "/b.lock"},   32'(err_lock_b), 32'(mPhase[1] == 3));
        checkOutput({tag, "/b.tout"},   32'(err_tout_b), 32'(mPhase[1] == 4));
        checkOutput({tag, "/b.period"}, 32'(period_b),   32'(mPeriod[1]));
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic s,
                                 input logic [3:0] w, input string tag);
        res   = r;
        en    = e;
        start = s;
        w_in  = w;
        @(posedge clk);
        modelStep(r, e, s, w);
        #1;
        compareAll(tag);
    endtask

    initial begin
        logic [3:0] w;
        logic [3:0] g;
        logic       r, e, s;

        res = 1'b0; en = 1'b0; start = 1'b0; w_in = 4'd0;
        for (int i = 0; i < 4; i++) begin
            mPhase[i % 2] = 0; mRef[i % 2] = 0; mSamples[i % 2] = 0; mPeriod[i % 2] = 0;
        end

        applyStimulus(1'b0, 1'b1, 1'b1, 4'hF, "reset");
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, "reset");
        checkOutput("reset.period", 32'(period_a), 32'd0);
        checkOutput("reset.busy", 32'(busy_a), 32'd0);

        // Test 1: full m-sequence from 1111
        w = 4'hF;
        applyStimulus(1'b1, 1'b1, 1'b1, w, "t1");
        for (int k = 1; k <= 15; k++) begin
            w = lfsrNext(w);
            applyStimulus(1'b1, 1'b1, 1'b0, w, "t1");
            if (k == 14) checkOutput("t1.busy14", 32'(busy_a), 32'd1);
        end
        checkOutput("t1.period", 32'(period_a), 32'd15);
        checkOutput("t1.done", 32'(done_a), 32'd1);

        // Test 2: lockup on zero, then restart clears it
        applyStimulus(1'b1, 1'b1, 1'b1, 4'b1001, "t2");
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0011, "t2");
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, "t2");
        checkOutput("t2.lock", 32'(err_lock_a), 32'd1);
        checkOutput("t2.done", 32'(done_a), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'b0110, "t2");
        checkOutput("t2.lockclr", 32'(err_lock_a), 32'd0);
        checkOutput("t2.busy", 32'(busy_a), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, "t2rst");

        // Test 3: counting stream 1..15,1; the MAX_PERIOD=10 monitor times out
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd1, "t3");
        for (int k = 2; k <= 16; k++) begin
            w = (k == 16) ? 4'd1 : 4'(k);
            applyStimulus(1'b1, 1'b1, 1'b0, w, "t3");
            if (k == 10) checkOutput("t3.busy10", 32'(busy_b), 32'd1);
            if (k == 11) checkOutput("t3.tout", 32'(err_tout_b), 32'd1);
        end
        checkOutput("t3.nodone", 32'(done_b), 32'd0);
        checkOutput("t3.a.period", 32'(period_a), 32'd15);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, "t3rst");

        // Test 4: en low every other cycle, start without en ignored
        applyStimulus(1'b1, 1'b0, 1'b1, 4'hF, "t4");
        checkOutput("t4.noarm", 32'(busy_a), 32'd0);
        w = 4'hF;
        applyStimulus(1'b1, 1'b1, 1'b1, w, "t4");
        for (int k = 1; k <= 15; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 4'($urandom_range(0, 15)), "t4");
            w = lfsrNext(w);
            applyStimulus(1'b1, 1'b1, 1'b0, w, "t4");
        end
        checkOutput("t4.period", 32'(period_a), 32'd15);

        // Test 5: reset mid-measurement, start during COUNT ignored, then re-measure
        w = 4'hF;
        applyStimulus(1'b1, 1'b1, 1'b1, w, "t5");
        for (int k = 1; k <= 6; k++) begin
            w = lfsrNext(w);
            applyStimulus(1'b1, 1'b1, (k == 3), w, "t5");
        end
        applyStimulus(1'b0, 1'b1, 1'b1, lfsrNext(w), "t5rst");
        checkOutput("t5.rstbusy", 32'(busy_a), 32'd0);
        checkOutput("t5.rstperiod", 32'(period_a), 32'd0);
        w = 4'hF;
        applyStimulus(1'b1, 1'b1, 1'b1, w, "t5");
        for (int k = 1; k <= 15; k++) begin
            w = lfsrNext(w);
            applyStimulus(1'b1, 1'b1, (k == 5), w, "t5");
        end
        checkOutput("t5.period", 32'(period_a), 32'd15);

        // Test 6: zero seed faults immediately, period held
        applyStimulus(1'b1, 1'b1, 1'b1, 4'h0, "t6");
        checkOutput("t6.lock", 32'(err_lock_a), 32'd1);
        checkOutput("t6.period", 32'(period_a), 32'd15);

        // Randomized stream: mostly LFSR words, occasional corrupt words, starts and resets
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, "rndrst");
        g = 4'($urandom_range(1, 15));
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(0, 199) != 0);
            e = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 99) < 5);
            w = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15)) : g;
            if (e) g = lfsrNext(g);
            applyStimulus(r, e, s, w, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
